keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 201 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one column low at a time, samples the row
// sense lines, debounces press and release, and reports the key index.
// Output handshake: key_valid is a single-cycle strobe with no back-pressure;
// key_code is meaningful on that cycle and holds until the next strobe.
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 3,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int CW              = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  output logic            key_held,
  output logic [1:0]      state_dbg
);

  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [CIW-1:0]  COL_LAST = CIW'(COLS - 1);
  localparam logic [CIW-1:0]  COL_ONE  = CIW'(1);
  localparam logic [DVW-1:0]  DIV_LAST = DVW'(SCAN_DIV - 1);
  localparam logic [DVW-1:0]  DIV_ONE  = DVW'(1);
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0]  DB_ONE   = DBW'(1);
  localparam logic [RPW-1:0]  RP_LAST  = RPW'(REPEAT_CYCLES - 1);
  localparam logic [RPW-1:0]  RP_ONE   = RPW'(1);
  localparam logic [ROWS-1:0] ROW_ONE  = ROWS'(1);
  localparam logic [COLS-1:0] COL_BIT  = COLS'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [ROWS-1:0] meta_q, rs;
  logic [CIW-1:0]  c_q, c_d, c_adv;
  logic [RW-1:0]   r_q, r_d, hit_row;
  logic [DVW-1:0]  div_q, div_d;
  logic [DBW-1:0]  db_q, db_d;
  logic [RPW-1:0]  rep_q, rep_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   code_q, code_d, cur_code;
  logic            held_q, held_d;
  logic [ROWS-1:0] row_low, key_pat;
  logic            one_low;

  // Two-flop synchronizer for the asynchronous row lines; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      rs     <= '1;
    end else begin
      meta_q <= row_in;
      rs     <= meta_q;
    end
  end

  // Row decode: detect exactly one low row, locate it, and build helpers.
  always_comb begin
    row_low  = ~rs;
    one_low  = (row_low != '0) && ((row_low & (row_low - ROW_ONE)) == '0);
    hit_row  = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (row_low[i]) hit_row = RW'(i);
    end
    key_pat  = ~(ROW_ONE << r_q);
    c_adv    = (c_q == COL_LAST) ? '0 : c_q + COL_ONE;
    cur_code = CW'(int'(c_q) * ROWS + int'(r_q));
  end

  // Next-state and datapath decisions; everything defaults to hold.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    div_d   = div_q;
    db_d    = db_q;
    rep_d   = rep_q;
    valid_d = 1'b0;
    code_d  = code_q;
    held_d  = held_q;
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (one_low) begin
            // Single key seen: stay on this column and start debouncing.
            r_d     = hit_row;
            db_d    = '0;
            state_d = PRESS_DB;
          end else begin
            // Idle or ghost pattern: move on to the next column.
            c_d = c_adv;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      PRESS_DB: begin
        if (rs == key_pat) begin
          if (db_q == DB_LAST) begin
            valid_d = 1'b1;
            code_d  = cur_code;
            held_d  = 1'b1;
            rep_d   = '0;
            state_d = HELD;
          end else begin
            db_d = db_q + DB_ONE;
          end
        end else begin
          state_d = SCAN;
          c_d     = c_adv;
          div_d   = '0;
        end
      end
      HELD: begin
        if (rs == '1) begin
          state_d = REL_DB;
          db_d    = '0;
        end else if (REPEAT_EN != 0) begin
          // Other non-idle patterns are ignored; only repeat timing runs.
          if (rep_q == RP_LAST) begin
            valid_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + RP_ONE;
          end
        end
      end
      REL_DB: begin
        if (rs == '1) begin
          if (db_q == DB_LAST) begin
            held_d  = 1'b0;
            state_d = SCAN;
            c_d     = c_adv;
            div_d   = '0;
          end else begin
            db_d = db_q + DB_ONE;
          end
        end else begin
          // Release bounced: back to held, restart repeat timing, no pulse.
          state_d = HELD;
          rep_d   = '0;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN;
      c_q     <= '0;
      r_q     <= '0;
      div_q   <= '0;
      db_q    <= '0;
      rep_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      div_q   <= div_d;
      db_q    <= db_d;
      rep_q   <= rep_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      held_q  <= held_d;
    end
  end

  // Column drive: the selected column is the only low bit.
  always_comb begin
    col_out = ~(COL_BIT << c_q);
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_held  = held_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural keypad matrix closes rows against
// the driven column; expected key codes are queued at stimulus time and a
// negedge monitor pops them whenever key_valid pulses.
module tb_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int CW   = 4;
  localparam int RC   = 20;

  localparam logic [1:0] ST_SCAN  = 2'd0;
  localparam logic [1:0] ST_PRESS = 2'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic [ROWS-1:0] row_in, row_in_r;
  logic [COLS-1:0] col_out, col_out_r;
  logic            key_valid, key_valid_r;
  logic [CW-1:0]   key_code, key_code_r;
  logic            key_held, key_held_r;
  logic [1:0]      state_dbg, state_dbg_r;
  logic [ROWS*COLS-1:0] pressed, pressed_r;

  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8),
                   .REPEAT_EN(0), .REPEAT_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held),
    .state_dbg(state_dbg));

  keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8),
                   .REPEAT_EN(1), .REPEAT_CYCLES(RC)) dut_r (
    .clk(clk), .rst(rst), .row_in(row_in_r), .col_out(col_out_r),
    .key_valid(key_valid_r), .key_code(key_code_r), .key_held(key_held_r),
    .state_dbg(state_dbg_r));

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_in   = '1;
    row_in_r = '1;
    for (int k = 0; k < COLS; k++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!col_out[k] && pressed[k*ROWS+r])     row_in[r]   = 1'b0;
        if (!col_out_r[k] && pressed_r[k*ROWS+r]) row_in_r[r] = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_q_r[$];
  int last_r;
  int pulses_r;
  logic [2:0] idle_pat [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the non-repeating scanner.
  always @(negedge clk) begin
    logic [CW-1:0] e;
    if (!rst && key_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: key_code=%0d with nothing expected (cycle %0d)", key_code, cyc);
      end else begin
        e = exp_q.pop_front();
        check("key_code", {28'd0, key_code}, {28'd0, e});
        check("held_at_pulse", {31'd0, key_held}, 32'd1);
      end
    end
  end

  // Monitor for the auto-repeat scanner, also checking pulse spacing.
  always @(negedge clk) begin
    logic [CW-1:0] e;
    if (!rst && key_valid_r) begin
      pulses_r++;
      if (exp_q_r.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_repeat_pulse: key_code=%0d with nothing expected (cycle %0d)", key_code_r, cyc);
      end else begin
        e = exp_q_r.pop_front();
        check("repeat_key_code", {28'd0, key_code_r}, {28'd0, e});
      end
      if (last_r >= 0) check("repeat_gap", cyc - last_r, RC);
      last_r = cyc;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_held(input logic lvl, input int bound, output int n);
    n = 0;
    while (key_held !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_held", {31'd0, key_held}, {31'd0, lvl});
  endtask

  task automatic wait_col(input logic [2:0] pat, input int bound, output int n);
    n = 0;
    while (col_out !== pat && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_col", {29'd0, col_out}, {29'd0, pat});
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    idle_pat[0] = 3'b110;
    idle_pat[1] = 3'b101;
    idle_pat[2] = 3'b011;
    pressed   = '0;
    pressed_r = '0;
    last_r    = -1;
    pulses_r  = 0;

    // Reset values.
    do_reset(3);
    check("rst_col_out", {29'd0, col_out}, 32'b110);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_key_held", {31'd0, key_held}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, ST_SCAN});
    check("rst_col_out_r", {29'd0, col_out_r}, 32'b110);

    // Idle scan: each column for four cycles, wrapping.
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      check("idle_col", {29'd0, col_out}, {29'd0, idle_pat[(i/4)%3]});
      check("idle_col_r", {29'd0, col_out_r}, {29'd0, idle_pat[(i/4)%3]});
      @(negedge clk);
    end

    // Clean press of key 9 (column 2, row 1).
    pressed[9] = 1'b1;
    exp_q.push_back(4'd9);
    repeat (40) @(negedge clk);
    check("press_held", {31'd0, key_held}, 32'd1);
    pressed = '0;
    wait_held(1'b0, 30, n);
    check("release_db_len", {31'd0, (n >= 8)}, 32'd1);
    check("resume_col0", {29'd0, col_out}, 32'b110);
    check("press_q_empty", exp_q.size(), 32'd0);

    // Bouncing press of key 5 (column 1, row 1).
    exp_q.push_back(4'd5);
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) pressed[5] = ~pressed[5];
      @(negedge clk);
    end
    check("bounce_no_pulse", exp_q.size(), 32'd1);
    pressed[5] = 1'b1;
    wait_held(1'b1, 40, n);
    repeat (5) @(negedge clk);
    pressed = '0;
    wait_held(1'b0, 30, n);
    check("bounce_q_empty", exp_q.size(), 32'd0);

    // Ghost: rows 0 and 2 together on column 0.
    pressed[0] = 1'b1;
    pressed[2] = 1'b1;
    wait_col(3'b110, 20, n);
    wait_col(3'b101, 8, n);
    check("ghost_adv_cycles", {31'd0, (n <= 4)}, 32'd1);
    repeat (20) @(negedge clk);
    check("ghost_no_held", {31'd0, key_held}, 32'd0);
    pressed = '0;
    check("ghost_q_empty", exp_q.size(), 32'd0);

    // Reset while a key is held.
    pressed[3] = 1'b1;
    exp_q.push_back(4'd3);
    wait_held(1'b1, 40, n);
    repeat (3) @(negedge clk);
    do_reset(2);
    rst = 1'b0;
    pressed = '0;
    check("hold_rst_held", {31'd0, key_held}, 32'd0);
    check("hold_rst_state", {30'd0, state_dbg}, {30'd0, ST_SCAN});
    @(negedge clk);
    check("hold_rst_col0", {29'd0, col_out}, 32'b110);
    repeat (20) @(negedge clk);
    check("hold_rst_q_empty", exp_q.size(), 32'd0);

    // Reset mid press-debounce, nine cycles after release of reset.
    do_reset(2);
    rst = 1'b0;
    pressed[0] = 1'b1;
    repeat (9) @(negedge clk);
    check("mid_db_state", {30'd0, state_dbg}, {30'd0, ST_PRESS});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pressed = '0;
    @(negedge clk);
    check("db_rst_first_col", {29'd0, col_out}, 32'b110);
    check("db_rst_state", {30'd0, state_dbg}, {30'd0, ST_SCAN});
    repeat (30) @(negedge clk);
    check("db_rst_held", {31'd0, key_held}, 32'd0);
    check("db_rst_q_empty", exp_q.size(), 32'd0);

    // Auto-repeat: key 5 held 70 cycles -> pulses 20 cycles apart.
    do_reset(2);
    last_r   = -1;
    pulses_r = 0;
    repeat (3) exp_q_r.push_back(4'd5);
    rst = 1'b0;
    pressed_r[5] = 1'b1;
    repeat (70) @(negedge clk);
    pressed_r = '0;
    repeat (30) @(negedge clk);
    check("repeat_count", pulses_r, 32'd3);
    check("repeat_q_empty", exp_q_r.size(), 32'd0);
    check("repeat_held_clear", {31'd0, key_held_r}, 32'd0);
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
